// File: rtl/atx_pkg.sv
// Shared ATX control definitions: control-state codes, status frame layout and
// the SDO query/CRC constants used by sdo_responder (CRC via SDO_RESPONDER_CRC_EN).
package atx_pkg;

    typedef enum logic [1:0] {
        CTL_RESET    = 2'b00,
        CTL_POWER_ON = 2'b01,
        CTL_ICE_CONF = 2'b10,
        CTL_ICE_GOOD = 2'b11
    } ctl_state_t;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'b00,
        ST_SEND  = 2'b01,
        ST_TRAIL = 2'b10
    } resp_state_t;

    localparam logic [7:0] QUERY_HDR_DEFAULT = 8'b01101001;
    localparam logic [3:0] STATUS_MAGIC      = 4'b1010;

    localparam int STATUS_LEN = 16;
    localparam int CRC_LEN    = 4;

    // x^4 + x + 1 with the x^4 term implied by the shift-out
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    localparam int FRM_MAGIC_MSB    = 15;
    localparam int FRM_MAGIC_LSB    = 12;
    localparam int FRM_CTL_MSB      = 11;
    localparam int FRM_CTL_LSB      = 10;
    localparam int FRM_CS_PGOOD     = 9;
    localparam int FRM_MAIN_EN      = 8;
    localparam int FRM_ICE_CDONE    = 7;
    localparam int FRM_WDOG_TIMEOUT = 6;
    localparam int FRM_ICE_POWER    = 5;
    localparam int FRM_WDOG_INHIBIT = 4;
    localparam int FRM_SEQ_MSB      = 3;
    localparam int FRM_SEQ_LSB      = 0;

    typedef struct packed {
        logic cs_pgood;
        logic main_en;
        logic ice_cdone;
        logic wdog_timeout;
        logic ice_power;
        logic wdog_inhibit;
    } status_flags_t;

    function automatic logic [STATUS_LEN-1:0] pack_status(
        input logic [3:0]    magic,
        input logic [1:0]    ctl,
        input status_flags_t flags,
        input logic [3:0]    seq
    );
        logic [STATUS_LEN-1:0] frame;
        frame = '0;
        frame[FRM_MAGIC_MSB:FRM_MAGIC_LSB] = magic;
        frame[FRM_CTL_MSB:FRM_CTL_LSB]     = ctl;
        frame[FRM_CS_PGOOD:FRM_WDOG_INHIBIT] = flags;
        frame[FRM_SEQ_MSB:FRM_SEQ_LSB]     = seq;
        return frame;
    endfunction

endpackage

// File: rtl/sdo_crc4.sv
// Serial CRC-4 (x^4+x+1, init 0) accumulator, one data bit per enabled sclk edge;
// instantiated by sdo_responder only when SDO_RESPONDER_CRC_EN is defined.
module sdo_crc4 (
    input  logic       sclk,
    input  logic       n_ice_reset,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_data,
    output logic [3:0] o_crc
);
    import atx_pkg::*;

    logic [3:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[3] ^ i_data;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            r_crc <= '0;
        end else if (i_clear) begin
            r_crc <= '0;
        end else if (i_enable) begin
            r_crc <= {r_crc[2:0], 1'b0} ^ ({4{w_fb}} & CRC4_POLY);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sdo_responder.sv
// Hunts for a query header on sdi and answers with a status frame on sdo.
// Defining SDO_RESPONDER_CRC_EN appends a serial CRC-4 to every frame.
module sdo_responder #(
    parameter logic [7:0] QUERY_HDR    = atx_pkg::QUERY_HDR_DEFAULT,
    parameter logic [3:0] STATUS_MAGIC = atx_pkg::STATUS_MAGIC
) (
    input  logic       sclk,
    input  logic       n_ice_reset,
    input  logic       sdi,
    input  logic       sdo_enable,
    input  logic [1:0] ctl_state,
    input  logic       cs_pgood,
    input  logic       main_en,
    input  logic       ice_cdone,
    input  logic       wdog_timeout,
    input  logic       ice_power,
    input  logic       wdog_inhibit,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       busy
);
    import atx_pkg::*;

`ifdef SDO_RESPONDER_CRC_EN
    localparam int FRAME_LEN = STATUS_LEN + CRC_LEN;
`else
    localparam int FRAME_LEN = STATUS_LEN;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    resp_state_t           r_state;
    resp_state_t           w_state_next;
    logic [7:0]            r_hdr;
    logic [7:0]            w_hdr_shift;
    logic [7:0]            w_hdr_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [STATUS_LEN-1:0] r_frame;
    logic [3:0]            r_seq;
    logic                  w_load;
    logic                  w_frame_done;
    logic                  w_sending;
    logic                  w_sdo_bit;
    status_flags_t         w_flags;

    assign w_flags     = {cs_pgood, main_en, ice_cdone, wdog_timeout, ice_power, wdog_inhibit};
    assign w_hdr_shift = {r_hdr[6:0], sdi};
    assign w_sending   = (r_state == ST_SEND);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_hdr_next   = r_hdr;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_hdr_next = w_hdr_shift;
                // A header arriving without SDO ownership is dropped, not deferred
                if ((w_hdr_shift == QUERY_HDR) && sdo_enable) begin
                    w_state_next = ST_SEND;
                    w_hdr_next   = '0;
                    w_cnt_next   = CNT_LAST;
                    w_load       = 1'b1;
                end
            end
            ST_SEND: begin
                if (!sdo_enable) begin
                    w_state_next = ST_HUNT;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_TRAIL;
                    w_frame_done = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_TRAIL: begin
                w_state_next = ST_HUNT;
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            r_state <= ST_HUNT;
            r_hdr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_hdr   <= w_hdr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Status is snapshotted once per frame, then shifted out MSB-first
    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            r_frame <= '0;
        end else if (w_load) begin
            r_frame <= pack_status(STATUS_MAGIC, ctl_state, w_flags, r_seq);
        end else if (w_sending && sdo_enable) begin
            r_frame <= {r_frame[STATUS_LEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            r_seq <= '0;
        end else if (w_frame_done) begin
            r_seq <= r_seq + 4'd1;
        end
    end

`ifdef SDO_RESPONDER_CRC_EN
    logic       w_in_crc;
    logic       w_crc_en;
    logic [3:0] w_crc;

    // The low CRC_LEN counts carry the remainder; above that the status bits feed the CRC
    assign w_in_crc = (r_cnt < CNT_W'(CRC_LEN));
    assign w_crc_en = w_sending && sdo_enable && !w_in_crc;

    sdo_crc4 u_crc (
        .sclk        (sclk),
        .n_ice_reset (n_ice_reset),
        .i_clear     (w_load),
        .i_enable    (w_crc_en),
        .i_data      (r_frame[STATUS_LEN-1]),
        .o_crc       (w_crc)
    );

    assign w_sdo_bit = w_in_crc ? w_crc[r_cnt[1:0]] : r_frame[STATUS_LEN-1];
`else
    assign w_sdo_bit = r_frame[STATUS_LEN-1];
`endif

    assign sdo    = w_sending ? w_sdo_bit : 1'b1;
    assign sdo_oe = sdo_enable && w_sending;
    assign busy   = w_sending;

endmodule

// File: tb/tb_sdo_responder.sv
// Directed bench for sdo_responder with a frame scoreboard and a CRC-4 long-division
// model; build with SDO_RESPONDER_CRC_EN defined to exercise the CRC variant.
module tb_sdo_responder;
    import atx_pkg::*;

`ifdef SDO_RESPONDER_CRC_EN
    localparam int FRAME_LEN = 20;
`else
    localparam int FRAME_LEN = 16;
`endif

    logic       sclk = 1'b0;
    logic       n_ice_reset = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo_enable = 1'b0;
    logic [1:0] ctl_state = 2'b00;
    logic       cs_pgood = 1'b0;
    logic       main_en = 1'b0;
    logic       ice_cdone = 1'b0;
    logic       wdog_timeout = 1'b0;
    logic       ice_power = 1'b0;
    logic       wdog_inhibit = 1'b0;
    logic       sdo;
    logic       sdo_oe;
    logic       busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [3:0]           m_seq = 4'd0;
    logic [FRAME_LEN-1:0] sb[$];

    sdo_responder dut (
        .sclk         (sclk),
        .n_ice_reset  (n_ice_reset),
        .sdi          (sdi),
        .sdo_enable   (sdo_enable),
        .ctl_state    (ctl_state),
        .cs_pgood     (cs_pgood),
        .main_en      (main_en),
        .ice_cdone    (ice_cdone),
        .wdog_timeout (wdog_timeout),
        .ice_power    (ice_power),
        .wdog_inhibit (wdog_inhibit),
        .sdo          (sdo),
        .sdo_oe       (sdo_oe),
        .busy         (busy)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] crc4_model(input logic [15:0] d);
        logic [19:0] r;
        r = {d, 4'b0000};
        for (int i = 19; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [FRAME_LEN-1:0] model_frame(input logic [15:0] st);
`ifdef SDO_RESPONDER_CRC_EN
        return {st, crc4_model(st)};
`else
        return st;
`endif
    endfunction

    function automatic logic [15:0] model_status();
        return {4'b1010, ctl_state, cs_pgood, main_en, ice_cdone,
                wdog_timeout, ice_power, wdog_inhibit, m_seq};
    endfunction

    task automatic set_default_status();
        ctl_state    = 2'b01;
        cs_pgood     = 1'b1;
        main_en      = 1'b1;
        ice_cdone    = 1'b0;
        wdog_timeout = 1'b0;
        ice_power    = 1'b1;
        wdog_inhibit = 1'b1;
    endtask

    task automatic send_header(input logic [7:0] hdr, input bit expect_frame);
        if (expect_frame) sb.push_back(model_frame(model_status()));
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk);
            sdi = hdr[i];
        end
    endtask

    task automatic receive_frame(input string tag, output logic [15:0] st);
        logic [FRAME_LEN-1:0] got;
        logic [FRAME_LEN-1:0] exp;
        bit oe_ok;
        bit busy_ok;
        oe_ok   = 1'b1;
        busy_ok = 1'b1;
        got     = '0;
        exp     = '0;
        for (int i = FRAME_LEN - 1; i >= 0; i--) begin
            @(negedge sclk);
            sdi    = 1'b0;
            got[i] = sdo;
            if (sdo_oe !== 1'b1) oe_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) exp = sb.pop_front();
        check(tag, 32'(got), 32'(exp));
        check({tag, "_oe"}, 32'(oe_ok), 32'd1);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        @(negedge sclk);
        check({tag, "_trail"}, {29'd0, sdo, sdo_oe, busy}, 32'b100);
        m_seq = m_seq + 4'd1;
        st = got[FRAME_LEN-1 -: 16];
    endtask

    task automatic idle_check(input string tag, input int n);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge sclk);
            sdi = 1'b0;
            if ({sdo, sdo_oe, busy} !== 3'b100) ok = 1'b0;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [15:0]          st;
        logic [3:0]           seq_before;
        logic [4:0]           got5;
        logic [FRAME_LEN-1:0] exp_abort;

        set_default_status();
        sdo_enable = 1'b1;
        #1;
        check("reset_outputs", {29'd0, sdo, sdo_oe, busy}, 32'b100);
        @(negedge sclk);
        n_ice_reset = 1'b0;

        // First query: fixed status pattern with seq 0
        send_header(8'b01101001, 1'b1);
        receive_frame("q0", st);
        check("q0_a730", 32'(st), 32'h0000_A730);
        check("q0_seq", 32'(st[3:0]), 32'd0);

        send_header(8'b01101001, 1'b1);
        receive_frame("q1", st);
        check("q1_seq", 32'(st[3:0]), 32'd1);
        send_header(8'b01101001, 1'b1);
        receive_frame("q2", st);
        check("q2_seq", 32'(st[3:0]), 32'd2);

        for (int k = 3; k < 16; k++) begin
            send_header(8'b01101001, 1'b1);
            receive_frame("qn", st);
        end
        send_header(8'b01101001, 1'b1);
        receive_frame("q16", st);
        check("seq_wrap", 32'(st[3:0]), 32'd0);

        // Random status snapshots; CRC tail checked through the model frame
        for (int k = 0; k < 32; k++) begin
            ctl_state    = 2'($urandom_range(0, 3));
            cs_pgood     = 1'($urandom_range(0, 1));
            main_en      = 1'($urandom_range(0, 1));
            ice_cdone    = 1'($urandom_range(0, 1));
            wdog_timeout = 1'($urandom_range(0, 1));
            ice_power    = 1'($urandom_range(0, 1));
            wdog_inhibit = 1'($urandom_range(0, 1));
            send_header(8'b01101001, 1'b1);
            receive_frame("rand", st);
        end
        set_default_status();

        // Header while SDO is not granted is ignored
        seq_before = m_seq;
        sdo_enable = 1'b0;
        send_header(8'b01101001, 1'b0);
        idle_check("ignored_hdr_idle", 4);
        sdo_enable = 1'b1;
        send_header(8'b01101001, 1'b1);
        receive_frame("after_ignored", st);
        check("after_ignored_seq", 32'(st[3:0]), 32'(seq_before));

        // Grant withdrawn after 5 frame bits
        seq_before = m_seq;
        send_header(8'b01101001, 1'b1);
        exp_abort = sb[0];
        for (int i = 4; i >= 0; i--) begin
            @(negedge sclk);
            sdi = 1'b0;
            got5[i] = sdo;
        end
        check("abort_bits", 32'(got5), 32'(exp_abort[FRAME_LEN-1 -: 5]));
        sdo_enable = 1'b0;
        #1;
        check("abort_oe_same_cycle", {30'd0, sdo_oe, busy}, 32'b01);
        @(negedge sclk);
        check("abort_hunt", {29'd0, sdo, sdo_oe, busy}, 32'b100);
        void'(sb.pop_front());
        sdo_enable = 1'b1;
        send_header(8'b01101001, 1'b1);
        receive_frame("after_abort", st);
        check("after_abort_seq", 32'(st[3:0]), 32'(seq_before));

        // Reset pulse in the middle of a frame
        send_header(8'b01101001, 1'b1);
        repeat (3) @(negedge sclk);
        n_ice_reset = 1'b1;
        #1;
        check("rst_mid_frame", {29'd0, sdo, sdo_oe, busy}, 32'b100);
        void'(sb.pop_front());
        m_seq = 4'd0;
        @(negedge sclk);
        n_ice_reset = 1'b0;
        send_header(8'b01101001, 1'b1);
        receive_frame("after_rst", st);
        check("after_rst_seq", 32'(st[3:0]), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdo_responder.md
SDO_RESPONDER -- requirements
Module: sdo_responder

Interface
REQ-001 Parameter: QUERY_HDR, 8'b01101001, query header matched MSB-first on sdi.
REQ-002 Parameter: STATUS_MAGIC, 4'b1010, fixed tag in frame bits [15:12].
REQ-003 Port: sclk  in  1  SPI clock; all sequential logic on posedge.
REQ-004 Port: n_ice_reset  in  1  reset, asynchronous, active-high (responder held idle while iCE is out of reset and owns SDO).
REQ-005 Port: sdi  in  1  serial data from host.
REQ-006 Port: sdo_enable  in  1  SDO ownership grant from the ATX control block.
REQ-007 Port: ctl_state  in  2  control state code (RESET/POWER_ON/ICE_CONF/ICE_GOOD).
REQ-008 Port: cs_pgood, main_en, ice_cdone, wdog_timeout, ice_power, wdog_inhibit  in  1 each  status flags.
REQ-009 Port: sdo  out  1  serial status data, idle high.
REQ-010 Port: sdo_oe  out  1  SDO pad output enable.
REQ-011 Port: busy  out  1  high while a frame is being shifted.

Function
REQ-012 States SHALL be HUNT, SEND, TRAIL.
REQ-013 HUNT: 8-bit shift register SHALL take sdi each posedge; register == QUERY_HDR -> SEND on that same edge.
REQ-014 Entering SEND: snapshot SHALL latch frame = {STATUS_MAGIC, ctl_state, cs_pgood, main_en, ice_cdone, wdog_timeout, ice_power, wdog_inhibit, seq[3:0]}; header register cleared.
REQ-015 sdo SHALL present frame MSB immediately after the header-completing edge, one bit per subsequent posedge; bit counter FRAME_LEN-1 down to 0.
REQ-016 sdi SHALL be ignored during SEND and TRAIL; no header detection overlaps a frame.
REQ-017 After the last bit: TRAIL for one cycle with sdo=1, then HUNT.
REQ-018 seq SHALL be a 4-bit counter incremented on each completed frame (entry to TRAIL), wrapping 15 -> 0.
REQ-019 sdo_oe SHALL be combinational: sdo_enable AND (state == SEND).
REQ-020 sdo_enable low during SEND SHALL abort to HUNT at the next posedge, sdo=1, seq unchanged.
REQ-021 Header completing while sdo_enable low SHALL be ignored (remain in HUNT).
REQ-022 busy SHALL equal (state == SEND).

Reset
REQ-023 n_ice_reset high SHALL immediately force HUNT, header register 0, seq 0, sdo=1, sdo_oe=0, busy=0, including mid-frame.
REQ-024 Reset release SHALL begin header hunting at the first posedge after release.

Configuration
REQ-025 Macro SDO_RESPONDER_CRC_EN defined: FRAME_LEN=20; serial CRC-4 (x^4+x+1, init 0) over the 16 frame bits appended MSB-first after bit 0.
REQ-026 Macro SDO_RESPONDER_CRC_EN undefined: FRAME_LEN=16, no CRC logic synthesised.

Structure
REQ-027 Shared package atx_pkg SHALL hold the control-state codes, STATUS_MAGIC, QUERY_HDR default and the frame-bit index constants.
REQ-028 CRC SHALL be the sub-module sdo_crc4 (clear, enable, data-in, 4-bit remainder), instantiated only under SDO_RESPONDER_CRC_EN.

Verification
REQ-029 Reset deasserted, sdo_enable=1, ctl_state=2'b01, cs_pgood=main_en=ice_power=wdog_inhibit=1, others 0, send 01101001 -> sdo shifts 0xA730 MSB-first, sdo_oe high 16 (or 20) cycles.
REQ-030 Three back-to-back queries -> seq fields 0,1,2; after 16 queries seq wraps to 0.
REQ-031 Header sent with sdo_enable=0 -> sdo_oe stays 0, sdo stays 1, seq unchanged.
REQ-032 sdo_enable dropped after 5 frame bits -> sdo_oe 0 same cycle, HUNT next edge, next frame seq unchanged.
REQ-033 n_ice_reset pulsed high mid-frame -> sdo=1, sdo_oe=0 immediately; next frame seq=0.
REQ-034 With SDO_RESPONDER_CRC_EN, 32 random-status queries -> last 4 bits match bench CRC-4 model every frame.
